// File: rtl/video_in_capture.sv
// video_in_capture
// Captures raster video from a display-timing source (frame_valid/line_valid)
// and forwards accepted pixels to a downstream FIFO one cycle later.
// Line/frame geometry is checked against P_WIDTH x P_HEIGHT; violations and
// FIFO overflows are reported on sticky flags cleared by err_clr.
//
// Ports
//   clk            single clock
//   RST            synchronous active-high reset
//   line_valid     line active from display
//   frame_valid    frame active from display
//   pixel_in       pixel data, valid when line_valid and frame_valid are high
//   fifo_full      downstream FIFO cannot accept a write this cycle
//   err_clr        clears all sticky error flags
//   w_e            FIFO write enable
//   pixel_out      registered pixel, qualified by w_e
//   sof / eol      first pixel of frame / last pixel of line (output cycle)
//   err_*          sticky error flags
//   frame_cnt      completed frames, wraps
//
// state        | meaning
// S_IDLE       | after reset, wait for frame_valid low (never start mid-frame)
// S_WAIT_FV    | wait for frame start
// S_WAIT_LV    | inside frame, waiting for the next line
// S_ACTIVE     | line in progress, accepting pixels
// S_WAIT_FV_LOW| all lines received, waiting for frame end
module video_in_capture #(
  parameter int P_WIDTH  = 640,
  parameter int P_HEIGHT = 480,
  parameter int P_PIX_W  = 8,
  parameter int P_CNT_W  = 10
) (
  input  logic               clk,
  input  logic               RST,
  input  logic               line_valid,
  input  logic               frame_valid,
  input  logic [P_PIX_W-1:0] pixel_in,
  input  logic               fifo_full,
  input  logic               err_clr,
  output logic               w_e,
  output logic [P_PIX_W-1:0] pixel_out,
  output logic               sof,
  output logic               eol,
  output logic               err_short_line,
  output logic               err_long_line,
  output logic               err_frame,
  output logic               err_overflow,
  output logic [15:0]        frame_cnt
);

  localparam logic [P_CNT_W-1:0] L_W      = P_CNT_W'(P_WIDTH);
  localparam logic [P_CNT_W-1:0] L_W_LAST = P_CNT_W'(P_WIDTH - 1);
  localparam logic [P_CNT_W-1:0] L_H      = P_CNT_W'(P_HEIGHT);

  typedef enum logic [2:0] {
    S_IDLE, S_WAIT_FV, S_WAIT_LV, S_ACTIVE, S_WAIT_FV_LOW
  } state_t;

  state_t state, state_nxt;

  logic [P_CNT_W-1:0] pixel_c, pixel_l;
  logic [P_CNT_W-1:0] pixel_l_inc;

  logic accept, drop_long, line_end, short_ev, frame_ev, frame_done, cnt_clr;

  assign pixel_l_inc = pixel_l + P_CNT_W'(1);

  always_ff @(posedge clk) begin
    if (RST) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:        if (!frame_valid) state_nxt = S_WAIT_FV;
      S_WAIT_FV:     if (frame_valid) state_nxt = S_WAIT_LV;
      S_WAIT_LV: begin
        if (!frame_valid)    state_nxt = S_WAIT_FV;
        else if (line_valid) state_nxt = S_ACTIVE;
      end
      S_ACTIVE: begin
        if (!frame_valid)     state_nxt = S_WAIT_FV;
        else if (!line_valid) state_nxt = (pixel_l_inc == L_H) ? S_WAIT_FV_LOW : S_WAIT_LV;
      end
      S_WAIT_FV_LOW: if (!frame_valid) state_nxt = S_WAIT_FV;
      default:       state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    accept     = 1'b0;
    drop_long  = 1'b0;
    line_end   = 1'b0;
    frame_ev   = 1'b0;
    frame_done = 1'b0;
    cnt_clr    = 1'b0;
    case (state)
      S_WAIT_FV: cnt_clr = frame_valid;
      S_WAIT_LV: begin
        if (!frame_valid)    frame_ev = 1'b1;
        else if (line_valid) accept   = 1'b1;
      end
      S_ACTIVE: begin
        if (!frame_valid) begin
          line_end = 1'b1;
          frame_ev = 1'b1;
        end else if (line_valid) begin
          if (pixel_c < L_W) accept    = 1'b1;
          else               drop_long = 1'b1;
        end else begin
          line_end = 1'b1;
        end
      end
      S_WAIT_FV_LOW: begin
        if (line_valid)   frame_ev   = 1'b1;
        if (!frame_valid) frame_done = 1'b1;
      end
      default: ;
    endcase
    short_ev = line_end && (pixel_c != L_W);
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      w_e            <= 1'b0;
      pixel_out      <= '0;
      sof            <= 1'b0;
      eol            <= 1'b0;
      pixel_c        <= '0;
      pixel_l        <= '0;
      err_short_line <= 1'b0;
      err_long_line  <= 1'b0;
      err_frame      <= 1'b0;
      err_overflow   <= 1'b0;
      frame_cnt      <= '0;
    end else begin
      // Overflow only gates the write; position markers still follow the raster.
      w_e <= accept & ~fifo_full;
      if (accept) pixel_out <= pixel_in;
      sof <= accept && (pixel_c == '0) && (pixel_l == '0);
      eol <= accept && (pixel_c == L_W_LAST);

      if (cnt_clr) begin
        pixel_c <= '0;
        pixel_l <= '0;
      end else if (accept) begin
        pixel_c <= pixel_c + P_CNT_W'(1);
      end else if (line_end) begin
        pixel_c <= '0;
        pixel_l <= pixel_l_inc;
      end

      // A set event in the same cycle as err_clr wins.
      err_short_line <= short_ev             | (err_short_line & ~err_clr);
      err_long_line  <= drop_long            | (err_long_line  & ~err_clr);
      err_frame      <= frame_ev             | (err_frame      & ~err_clr);
      err_overflow   <= (accept & fifo_full) | (err_overflow   & ~err_clr);

      if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_video_in_capture.sv
module tb_video_in_capture;

  logic       clk = 1'b0;
  logic       RST = 1'b1;
  logic       line_valid = 1'b0;
  logic       frame_valid = 1'b0;
  logic [7:0] pixel_in = 8'h00;
  logic       fifo_full = 1'b0;
  logic       err_clr = 1'b0;
  logic       w_e;
  logic [7:0] pixel_out;
  logic       sof, eol;
  logic       err_short_line, err_long_line, err_frame, err_overflow;
  logic [15:0] frame_cnt;

  int checks = 0;
  int errors = 0;

  logic [7:0] wdata[$];
  int         sof_pos[$];
  int         eol_pos[$];
  logic [7:0] exp_data[$];

  video_in_capture #(
    .P_WIDTH(4), .P_HEIGHT(3), .P_PIX_W(8), .P_CNT_W(10)
  ) dut (
    .clk(clk), .RST(RST), .line_valid(line_valid), .frame_valid(frame_valid),
    .pixel_in(pixel_in), .fifo_full(fifo_full), .err_clr(err_clr),
    .w_e(w_e), .pixel_out(pixel_out), .sof(sof), .eol(eol),
    .err_short_line(err_short_line), .err_long_line(err_long_line),
    .err_frame(err_frame), .err_overflow(err_overflow), .frame_cnt(frame_cnt)
  );

  always #5 clk = ~clk;

  // Output monitor samples on the falling edge.
  always @(negedge clk) begin
    if (w_e) wdata.push_back(pixel_out);
    if (sof) sof_pos.push_back(wdata.size());
    if (eol) eol_pos.push_back(wdata.size());
  end

  task automatic cyc(input logic fv, input logic lv, input int pix, input logic full, input logic clr);
    frame_valid = fv;
    line_valid  = lv;
    pixel_in    = 8'(pix);
    fifo_full   = full;
    err_clr     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic clear_mon();
    wdata.delete();
    sof_pos.delete();
    eol_pos.delete();
    exp_data.delete();
  endtask

  task automatic frame_start();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic send_line(input int line, input int n, input int full_idx);
    for (int i = 0; i < n; i++) cyc(1, 1, line * 16 + i, (i == full_idx), 0);
    cyc(1, 0, 0, 0, 0);
  endtask

  task automatic frame_end();
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic exp_line(input int line, input int n, input int skip);
    for (int i = 0; i < n; i++) if (i != skip) exp_data.push_back(8'(line * 16 + i));
  endtask

  task automatic clear_errs();
    cyc(0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0);
  endtask

  task automatic check_data(input string name);
    checks++;
    if (wdata.size() !== exp_data.size()) begin
      errors++;
      $display("FAIL %s write count: got %0d expected %0d", name, wdata.size(), exp_data.size());
    end
    for (int i = 0; i < exp_data.size() && i < wdata.size(); i++) begin
      checks++;
      if (wdata[i] !== exp_data[i]) begin
        errors++;
        $display("FAIL %s data[%0d]: got %h expected %h", name, i, wdata[i], exp_data[i]);
      end
    end
  endtask

  task automatic test_reset();
    RST = 1'b1;
    cyc(0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0);
    checks++; if (w_e !== 1'b0) begin errors++; $display("FAIL reset w_e: got %b expected 0", w_e); end
    checks++; if (pixel_out !== 8'h00) begin errors++; $display("FAIL reset pixel_out: got %h expected 00", pixel_out); end
    checks++; if ({sof, eol} !== 2'b00) begin errors++; $display("FAIL reset sof/eol: got %b expected 00", {sof, eol}); end
    checks++;
    if ({err_short_line, err_long_line, err_frame, err_overflow} !== 4'b0000) begin
      errors++; $display("FAIL reset flags: got %b expected 0000", {err_short_line, err_long_line, err_frame, err_overflow});
    end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset frame_cnt: got %0d expected 0", frame_cnt); end
    RST = 1'b0;
  endtask

  task automatic test_legal_frame();
    clear_mon();
    frame_start();
    for (int l = 0; l < 3; l++) begin send_line(l, 4, -1); exp_line(l, 4, -1); end
    frame_end();
    check_data("legal");
    checks++;
    if (sof_pos.size() !== 1 || sof_pos[0] !== 1) begin
      errors++; $display("FAIL legal sof: got %0d pulses expected 1 at write 1", sof_pos.size());
    end
    checks++;
    if (eol_pos.size() !== 3 || eol_pos[0] !== 4 || eol_pos[1] !== 8 || eol_pos[2] !== 12) begin
      errors++; $display("FAIL legal eol: got %0d pulses expected 3 at writes 4,8,12", eol_pos.size());
    end
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL legal frame_cnt: got %0d expected 1", frame_cnt); end
    checks++;
    if ({err_short_line, err_long_line, err_frame, err_overflow} !== 4'b0000) begin
      errors++; $display("FAIL legal flags: got %b expected 0000", {err_short_line, err_long_line, err_frame, err_overflow});
    end
  endtask

  task automatic test_long_short();
    clear_mon();
    frame_start();
    send_line(0, 5, -1); exp_line(0, 4, -1);
    send_line(1, 3, -1); exp_line(1, 3, -1);
    send_line(2, 4, -1); exp_line(2, 4, -1);
    frame_end();
    check_data("long_short");
    checks++; if (err_long_line !== 1'b1) begin errors++; $display("FAIL long flag: got %b expected 1", err_long_line); end
    checks++; if (err_short_line !== 1'b1) begin errors++; $display("FAIL short flag: got %b expected 1", err_short_line); end
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL long_short err_frame: got %b expected 0", err_frame); end
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL long_short frame_cnt: got %0d expected 2", frame_cnt); end
    clear_errs();
    checks++;
    if ({err_short_line, err_long_line} !== 2'b00) begin
      errors++; $display("FAIL err_clr short/long: got %b expected 00", {err_short_line, err_long_line});
    end
  endtask

  task automatic test_overflow();
    clear_mon();
    frame_start();
    send_line(0, 4, -1); exp_line(0, 4, -1);
    send_line(1, 4, 2);  exp_line(1, 4, 2);
    send_line(2, 4, -1); exp_line(2, 4, -1);
    frame_end();
    check_data("overflow");
    checks++; if (err_overflow !== 1'b1) begin errors++; $display("FAIL overflow flag: got %b expected 1", err_overflow); end
    checks++;
    if (eol_pos.size() !== 3 || eol_pos[0] !== 4 || eol_pos[1] !== 7 || eol_pos[2] !== 11) begin
      errors++; $display("FAIL overflow eol: got %0d pulses expected 3 at writes 4,7,11", eol_pos.size());
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL overflow frame_cnt: got %0d expected 3", frame_cnt); end
    clear_errs();
    checks++; if (err_overflow !== 1'b0) begin errors++; $display("FAIL overflow clr: got %b expected 0", err_overflow); end
  endtask

  task automatic test_frame_err();
    clear_mon();
    frame_start();
    send_line(0, 4, -1);
    send_line(1, 4, -1);
    frame_end();
    checks++; if (err_frame !== 1'b1) begin errors++; $display("FAIL frame_err flag: got %b expected 1", err_frame); end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL frame_err frame_cnt: got %0d expected 3", frame_cnt); end
    checks++; if (wdata.size() !== 8) begin errors++; $display("FAIL frame_err writes: got %0d expected 8", wdata.size()); end
    clear_errs();
    clear_mon();
    frame_start();
    for (int l = 0; l < 3; l++) begin send_line(l, 4, -1); exp_line(l, 4, -1); end
    frame_end();
    check_data("after_frame_err");
    checks++; if (frame_cnt !== 16'd4) begin errors++; $display("FAIL recovery frame_cnt: got %0d expected 4", frame_cnt); end
    checks++; if (err_frame !== 1'b0) begin errors++; $display("FAIL recovery err_frame: got %b expected 0", err_frame); end
  endtask

  task automatic test_reset_midline();
    clear_mon();
    frame_start();
    cyc(1, 1, 8'h00, 0, 0);
    cyc(1, 1, 8'h01, 0, 0);
    RST = 1'b1;
    cyc(1, 1, 8'h02, 0, 0);
    cyc(1, 1, 8'h03, 0, 0);
    RST = 1'b0;
    clear_mon();
    cyc(1, 1, 8'h04, 0, 0);
    cyc(1, 0, 0, 0, 0);
    send_line(1, 4, -1);
    send_line(2, 4, -1);
    checks++; if (wdata.size() !== 0) begin errors++; $display("FAIL midreset writes: got %0d expected 0", wdata.size()); end
    frame_start();
    for (int l = 0; l < 3; l++) begin send_line(l, 4, -1); exp_line(l, 4, -1); end
    frame_end();
    check_data("post_reset");
    checks++; if (frame_cnt !== 16'd1) begin errors++; $display("FAIL post_reset frame_cnt: got %0d expected 1", frame_cnt); end
    checks++;
    if (sof_pos.size() !== 1 || sof_pos[0] !== 1) begin
      errors++; $display("FAIL post_reset sof: got %0d pulses expected 1 at write 1", sof_pos.size());
    end
  endtask

  task automatic test_clr_collision();
    clear_mon();
    frame_start();
    for (int i = 0; i < 5; i++) cyc(1, 1, i, 0, (i == 4));
    checks++; if (err_long_line !== 1'b1) begin errors++; $display("FAIL clr_collision long: got %b expected 1", err_long_line); end
    cyc(1, 0, 0, 0, 0);
    checks++; if (err_long_line !== 1'b1) begin errors++; $display("FAIL clr_collision hold: got %b expected 1", err_long_line); end
    send_line(1, 4, -1);
    send_line(2, 4, -1);
    frame_end();
    checks++; if (frame_cnt !== 16'd2) begin errors++; $display("FAIL clr_collision frame_cnt: got %0d expected 2", frame_cnt); end
    clear_errs();
    checks++; if (err_long_line !== 1'b0) begin errors++; $display("FAIL clr_collision clr: got %b expected 0", err_long_line); end
  endtask

  initial begin
    test_reset();
    test_legal_frame();
    test_long_short();
    test_overflow();
    test_frame_err();
    test_reset_midline();
    test_clr_collision();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/video_in_capture.md
VIDEO_IN_CAPTURE -- requirements
Module: video_in_capture

Interface
REQ-001 Parameter: P_WIDTH, 640, active pixels per line.
REQ-002 Parameter: P_HEIGHT, 480, active lines per frame.
REQ-003 Parameter: P_PIX_W, 8, pixel data width in bits.
REQ-004 Parameter: P_CNT_W, 10, pixel/line counter width; SHALL satisfy 2^P_CNT_W > max(P_WIDTH, P_HEIGHT).
REQ-005 Port: clk  in  1  single clock for all logic.
REQ-006 Port: RST  in  1  reset, synchronous, active-high.
REQ-007 Port: line_valid  in  1  line active from display.
REQ-008 Port: frame_valid  in  1  frame active from display.
REQ-009 Port: pixel_in  in  P_PIX_W  pixel data, valid when line_valid and frame_valid are both high.
REQ-010 Port: fifo_full  in  1  downstream FIFO cannot accept a write this cycle.
REQ-011 Port: err_clr  in  1  clears all sticky error flags.
REQ-012 Port: w_e  out  1  FIFO write enable.
REQ-013 Port: pixel_out  out  P_PIX_W  registered pixel, qualified by w_e.
REQ-014 Port: sof  out  1  pulse, output cycle of pixel (0,0).
REQ-015 Port: eol  out  1  pulse, output cycle of pixel P_WIDTH-1 of each line.
REQ-016 Port: err_short_line, err_long_line, err_frame, err_overflow  out  1 each  sticky error flags.
REQ-017 Port: frame_cnt  out  16  count of completed frames, wraps 0xFFFF->0.

Function
REQ-018 Input sampling: pixel_in is registered; an accepted pixel appears on pixel_out with w_e=1 exactly 1 cycle later.
REQ-019 FSM states: IDLE, WAIT_FV, WAIT_LV, ACTIVE, WAIT_FV_LOW.
REQ-020 IDLE: frame_valid=0 -> WAIT_FV (never start mid-frame).
REQ-021 WAIT_FV: frame_valid=1 -> WAIT_LV; pixel_c=0, pixel_l=0.
REQ-022 WAIT_LV: line_valid=1 -> ACTIVE, and the pixel is accepted in the same cycle; frame_valid=0 -> err_frame set, WAIT_FV.
REQ-023 ACTIVE: each cycle with line_valid=1 and pixel_c<P_WIDTH, the pixel is accepted and pixel_c increments.
REQ-024 ACTIVE, line_valid=1 with pixel_c==P_WIDTH: the pixel is dropped, err_long_line is set, and pixel_c holds.
REQ-025 ACTIVE, line_valid=0: if pixel_c!=P_WIDTH, err_short_line is set; pixel_c=0 and pixel_l increments; if the new pixel_l==P_HEIGHT -> WAIT_FV_LOW, else WAIT_LV.
REQ-026 ACTIVE, frame_valid=0: the line is terminated as in REQ-025 plus err_frame set; -> WAIT_FV; frame_cnt is not incremented.
REQ-027 WAIT_FV_LOW: line_valid=1 -> pixels dropped, err_frame set; frame_valid=0 -> frame_cnt+1, WAIT_FV.
REQ-028 Overflow: an accepted pixel while fifo_full=1 gives w_e=0 on the output cycle and sets err_overflow; counters, sof and eol advance as if written.
REQ-029 sof and eol are position-based and are asserted in the output cycle even when w_e is suppressed by overflow.
REQ-030 Sticky flags: set on the event and held until err_clr=1; if err_clr and a set event occur in the same cycle, the flag is set.
REQ-031 Counter arithmetic: unsigned P_CNT_W bits, no wrap reachable under legal parameters.

Reset
REQ-032 When RST=1 at a clk edge: state=IDLE; w_e=0; pixel_out=0; sof=0; eol=0; all error flags=0; frame_cnt=0; pixel_c=0; pixel_l=0.
REQ-033 Reset mid-line aborts capture with no further w_e; after RST deasserts, capture restarts only after frame_valid=0 is seen.

Verification
REQ-034 P_WIDTH=4, P_HEIGHT=3; one legal frame -> 12 w_e pulses with data in order; sof on the first, eol on the 4th/8th/12th; frame_cnt=1; no flags.
REQ-035 Line of 5 pixels -> 4 writes, err_long_line=1; line of 3 pixels -> 3 writes, err_short_line=1; after err_clr=1 for one cycle, both flags=0.
REQ-036 fifo_full=1 during pixel (1,2) -> 11 writes, err_overflow=1; eol still asserted for line 1.
REQ-037 frame_valid falls after 2 lines -> err_frame=1, frame_cnt unchanged; the next legal frame -> frame_cnt+1.
REQ-038 Release RST while frame_valid=1 and a line is active -> no w_e until frame_valid falls; the following full frame is captured correctly.
REQ-039 err_clr asserted in the same cycle as a long-line event -> err_long_line=1 on the next cycle.
